decode_regfile: RTL and testbench

Architectural register storage for the decode stage: 32 GPRs and 32 FPRs in one 64-entry array, addressed with the same 6-bit `{fp_src, reg}` encoding that fetch produces for hazard checking. Decode reads source operands combinationally in the same cycle. Write-back updates one entry, or an even/odd FPR pair for doubles, on the rising edge. The block also holds the FPSR, which fetch consumes for FP-conditional branches.

---
 rtl/decode_regfile.sv | 63 ++++++
 tb/tb_decode_regfile.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// decode_regfile: 64x32 GPR/FPR array with double-pair write-back and FPSR.
// Optional write-through bypass on all four read outputs: define REGFILE_BYPASS_EN.
module decode_regfile #(
    parameter int Depth = 64,
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:5]       Rs1Addr,
    input  logic [0:5]       Rs2Addr,
    output logic [0:Width-1] Rs1Data,
    output logic [0:Width-1] Rs2Data,
    output logic [0:Width-1] Rs1DataHi,
    output logic [0:Width-1] Rs2DataHi,
    input  logic             WrEn,
    input  logic             WrDouble,
    input  logic [0:5]       WrAddr,
    input  logic [0:Width-1] WrData,
    input  logic [0:Width-1] WrDataHi,
    input  logic             FpsrWe,
    input  logic [0:Width-1] FpsrIn,
    output logic [0:Width-1] FPSR
);
    logic [0:Width-1] mem_q [Depth];
    logic [0:Width-1] fpsr_q, fpsr_d;
    logic             dbl;
    logic [0:5]       ev_addr, od_addr;
    logic [0:5]       ra [4];
    logic [0:Width-1] rv [4];
    // Pair writes only apply to FPR targets; a GPR target degrades to a single write.
    assign dbl     = WrDouble && WrAddr[0];
    assign ev_addr = dbl ? {WrAddr[0:4], 1'b0} : WrAddr;
    assign od_addr = {WrAddr[0:4], 1'b1};
    assign fpsr_d  = FpsrWe ? FpsrIn : fpsr_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            fpsr_q <= '0;
        end else begin
            if (WrEn && ev_addr != 6'd0) mem_q[ev_addr] <= WrData;
            if (WrEn && dbl) mem_q[od_addr] <= WrDataHi;
            fpsr_q <= fpsr_d;
        end
    end
    assign ra[0] = Rs1Addr;
    assign ra[1] = Rs2Addr;
    assign ra[2] = {Rs1Addr[0:4], 1'b1};
    assign ra[3] = {Rs2Addr[0:4], 1'b1};
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rv[i] = (ra[i] == 6'd0) ? '0 : mem_q[ra[i]];
`ifdef REGFILE_BYPASS_EN
            if (WrEn && ra[i] != 6'd0)
                rv[i] = (dbl && ra[i] == od_addr) ? WrDataHi : (ra[i] == ev_addr) ? WrData : rv[i];
`endif
        end
    end
    assign Rs1Data   = rv[0];
    assign Rs2Data   = rv[1];
    assign Rs1DataHi = rv[2];
    assign Rs2DataHi = rv[3];
    assign FPSR      = fpsr_q;
endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: random + directed scoreboard bench for decode_regfile.
module tb_decode_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Rs1Addr, Rs2Addr, WrAddr;
    logic [31:0] Rs1Data, Rs2Data, Rs1DataHi, Rs2DataHi;
    logic        WrEn, WrDouble, FpsrWe;
    logic [31:0] WrData, WrDataHi, FpsrIn, FPSR;

    decode_regfile dut (
        .clk(clk), .reset(reset),
        .Rs1Addr(Rs1Addr), .Rs2Addr(Rs2Addr),
        .Rs1Data(Rs1Data), .Rs2Data(Rs2Data),
        .Rs1DataHi(Rs1DataHi), .Rs2DataHi(Rs2DataHi),
        .WrEn(WrEn), .WrDouble(WrDouble), .WrAddr(WrAddr),
        .WrData(WrData), .WrDataHi(WrDataHi),
        .FpsrWe(FpsrWe), .FpsrIn(FpsrIn), .FPSR(FPSR)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] r1, r2, r1h, r2h, fpsr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m [64];
    logic [31:0] m_fpsr;
    int          errors = 0;
    int          checks = 0;

    // Architectural view: what a read of index a returns during the current cycle.
    function automatic logic [31:0] ref_rd(input int a);
        logic [31:0] v;
        bit          pair;
        v    = (a == 0) ? 32'h0 : m[a];
        pair = WrDouble && (WrAddr >= 32);
`ifdef REGFILE_BYPASS_EN
        if (WrEn && a != 0) begin
            if (pair && a == (WrAddr | 1)) v = WrDataHi;
            else if (pair ? (a == (WrAddr & 62)) : (a == WrAddr)) v = WrData;
        end
`endif
        return v;
    endfunction

    task automatic cmp(input string tag, input string fld, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got %08h expected %08h", tag, fld, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.tag, "Rs1Data", Rs1Data, e.r1);
            cmp(e.tag, "Rs2Data", Rs2Data, e.r2);
            cmp(e.tag, "Rs1DataHi", Rs1DataHi, e.r1h);
            cmp(e.tag, "Rs2DataHi", Rs2DataHi, e.r2h);
            cmp(e.tag, "FPSR", FPSR, e.fpsr);
        end
    end

    task automatic step(input string tag, input bit chk, input logic rst_n,
                        input logic we, input logic dw, input logic [5:0] wa,
                        input logic [31:0] wd, input logic [31:0] wdh,
                        input logic fwe, input logic [31:0] fin,
                        input logic [5:0] r1, input logic [5:0] r2);
        exp_t e;
        reset = rst_n; WrEn = we; WrDouble = dw; WrAddr = wa; WrData = wd; WrDataHi = wdh;
        FpsrWe = fwe; FpsrIn = fin; Rs1Addr = r1; Rs2Addr = r2;
        if (chk) begin
            e.tag  = tag;
            e.r1   = ref_rd(int'(r1));
            e.r2   = ref_rd(int'(r2));
            e.r1h  = ref_rd(int'(r1) | 1);
            e.r2h  = ref_rd(int'(r2) | 1);
            e.fpsr = m_fpsr;
            sb.push_back(e);
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m[i] = 32'h0;
            m_fpsr = 32'h0;
        end else begin
            if (we) begin
                if (dw && wa >= 32) begin
                    m[wa & 62] = wd;
                    m[wa | 1]  = wdh;
                end else if (wa != 0) m[wa] = wd;
            end
            if (fwe) m_fpsr = fin;
        end
        #1;
    endtask

    task automatic rd(input string tag, input logic [5:0] r1, input logic [5:0] r2);
        step(tag, 1, 1, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        @(posedge clk); #1;
        step("init_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("pre_r5", 1, 1, 1, 0, 5, 32'h12345678, 0, 1, 32'hABCD0000, 4, 5);
        rd("pre_chk", 4, 5);
        step("rst_ovr", 1, 0, 1, 0, 9, 32'hDEADBEEF, 0, 1, 32'h7, 5, 9);
        rd("post_rst", 5, 9);
        rd("post_rst2", 8, 0);
        step("r0_wr", 1, 1, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
        rd("r0_rd", 0, 0);
        step("f5_wr", 1, 1, 1, 0, 37, 32'hCAFEBABE, 0, 0, 0, 36, 37);
        rd("f5_rd", 37, 37);
        step("dbl34", 1, 1, 1, 1, 34, 32'h3FF00000, 32'h00000001, 0, 0, 34, 35);
        rd("dbl34_rd", 34, 35);
        step("r5_pre", 1, 1, 1, 0, 5, 32'h55555555, 0, 0, 0, 4, 5);
        step("dbl4", 1, 1, 1, 1, 4, 32'h3FF00000, 32'h00000001, 0, 0, 4, 5);
        rd("dbl4_rd", 4, 5);
        step("fpsr_gpr", 1, 1, 1, 0, 12, 32'h0BADF00D, 0, 1, 32'h1, 12, 13);
        rd("fpsr_rd", 12, 13);
        step("dbl63", 1, 1, 1, 1, 63, 32'h62626262, 32'h63636363, 0, 0, 62, 63);
        rd("dbl63_rd", 62, 63);
        step("dbl_odd_gpr", 1, 1, 1, 1, 7, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 6, 7);
        rd("dbl_odd_gpr_rd", 7, 6);
        for (int n = 0; n < 400; n++) begin
            logic [5:0] wa, r1, r2;
            wa = 6'($urandom_range(0, 63));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 6'($urandom_range(0, 63));
            step("rand", 1, ($urandom_range(0, 49) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa,
                 $urandom, $urandom, 1'($urandom_range(0, 3) == 0), $urandom, r1, r2);
        end
        rd("final", 1, 33);
        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
